// File: rtl/rfaludm_pkg.sv
// Shared definitions for the RFALUDM control sequencer: LEGv8 opcodes,
// ALUOp encodings, instruction classes and the sequencer state encoding.
package rfaludm_pkg;

    // Opcodes compared against instr[31:21]
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    // CBZ is identified by the 8-bit CB-format opcode in instr[31:24]
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    // ALUOp encodings seen by the ALU control
    localparam logic [1:0] ALUOP_NONE  = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_DADDR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_CBZ     = 3'd3,
        CLS_ILLEGAL = 3'd4
    } iclass_e;

endpackage

// File: rtl/rfaludm_sequencer_if.sv
// Bundle of the sequencer request inputs and all datapath-facing outputs.
// The master side (bench or CPU front end) drives start/instr/Zero.
interface rfaludm_sequencer_if;

    logic        start;
    logic [31:0] instr;
    logic        Zero;

    logic        busy;
    logic        done;
    logic        illegal;
    logic        branch_taken;
    logic [18:0] br_offset;

    logic [1:0]  ALUOp;
    logic [10:0] OpCodefield;
    logic [4:0]  Rn;
    logic [4:0]  Rm;
    logic [4:0]  Rt;
    logic [8:0]  DispIn;

    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrc_Select;
    logic        MemtoReg_Select;
    logic        Reg2Loc_Select;

    logic        RF_clock;
    logic        DM_clock;

    modport master (
        output start, instr, Zero,
        input  busy, done, illegal, branch_taken, br_offset,
        input  ALUOp, OpCodefield, Rn, Rm, Rt, DispIn,
        input  RegWrite, MemRead, MemWrite, ALUSrc_Select, MemtoReg_Select, Reg2Loc_Select,
        input  RF_clock, DM_clock
    );

    modport slave (
        input  start, instr, Zero,
        output busy, done, illegal, branch_taken, br_offset,
        output ALUOp, OpCodefield, Rn, Rm, Rt, DispIn,
        output RegWrite, MemRead, MemWrite, ALUSrc_Select, MemtoReg_Select, Reg2Loc_Select,
        output RF_clock, DM_clock
    );

endinterface

// File: rtl/rfaludm_decode.sv
// Combinational LEGv8 decode: instruction class plus the register and
// displacement fields the datapath consumes.
module rfaludm_decode
    import rfaludm_pkg::*;
(
    input  logic [31:0] i_instr,
    output iclass_e     o_class,
    output logic [10:0] o_opcode,
    output logic [4:0]  o_rn,
    output logic [4:0]  o_rm,
    output logic [4:0]  o_rt,
    output logic [8:0]  o_disp
);

    // instr[11:10] (the D-format op2 field) carries nothing this sequencer uses
    logic w_unused;
    assign w_unused = ^i_instr[11:10];

    assign o_opcode = i_instr[31:21];
    assign o_rm     = i_instr[20:16];
    assign o_disp   = i_instr[20:12];
    assign o_rn     = i_instr[9:5];
    assign o_rt     = i_instr[4:0];

    // Classify by opcode; CBZ is checked on its narrower 8-bit opcode first
    always_comb begin
        o_class = CLS_ILLEGAL;
        if (i_instr[31:24] == OPC_CBZ) begin
            o_class = CLS_CBZ;
        end else begin
            case (i_instr[31:21])
                OPC_LDUR: o_class = CLS_LOAD;
                OPC_STUR: o_class = CLS_STORE;
                OPC_ADD,
                OPC_SUB,
                OPC_AND,
                OPC_ORR:  o_class = CLS_RTYPE;
                default:  o_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/rfaludm_sequencer.sv
// Multicycle control sequencer for the RFALUDM datapath. One instruction
// is captured per start, then stepped through DECODE/EXEC/MEM/WB/DONE.
// Every output is a register loaded from the next-state value, so outputs
// line up with the state they describe and clear at once on reset.
module rfaludm_sequencer
    import rfaludm_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    rfaludm_sequencer_if.slave bus
);

    state_e      r_state;
    state_e      w_next_state;
    logic [31:0] r_instr;

    iclass_e     w_class;
    logic [10:0] w_opcode;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic [4:0]  w_rt;
    logic [8:0]  w_disp;

    logic [1:0]  w_alu_op;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_alu_src;
    logic        w_mem_to_reg;
    logic        w_reg2loc;

    logic        w_accept;
    logic        w_enter_exec;

    logic        r_busy;
    logic        r_done;
    logic        r_illegal;
    logic        r_branch_taken;
    logic [18:0] r_br_offset;
    logic [1:0]  r_alu_op;
    logic [10:0] r_opcode;
    logic [4:0]  r_rn;
    logic [4:0]  r_rm;
    logic [4:0]  r_rt;
    logic [8:0]  r_disp;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_alu_src;
    logic        r_mem_to_reg;
    logic        r_reg2loc;
    logic        r_rf_clock;
    logic        r_dm_clock;

    rfaludm_decode u_decode (
        .i_instr  (r_instr),
        .o_class  (w_class),
        .o_opcode (w_opcode),
        .o_rn     (w_rn),
        .o_rm     (w_rm),
        .o_rt     (w_rt),
        .o_disp   (w_disp)
    );

    assign w_accept     = (r_state == ST_IDLE) && bus.start;
    assign w_enter_exec = (r_state == ST_DECODE) && (w_next_state == ST_EXEC);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state selection and the control set implied by the decoded class
    always_comb begin
        w_next_state = r_state;
        w_alu_op     = ALUOP_NONE;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg2loc    = 1'b0;

        case (w_class)
            CLS_RTYPE: begin
                w_alu_op     = ALUOP_RTYPE;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            CLS_LOAD: begin
                w_alu_op    = ALUOP_DADDR;
                w_alu_src   = 1'b1;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
            end
            CLS_STORE: begin
                w_alu_op    = ALUOP_DADDR;
                w_alu_src   = 1'b1;
                w_reg2loc   = 1'b1;
                w_mem_write = 1'b1;
            end
            CLS_CBZ: begin
                w_alu_op  = ALUOP_PASSB;
                w_reg2loc = 1'b1;
            end
            default: ;
        endcase

        case (r_state)
            ST_IDLE:   if (bus.start) w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = (w_class == CLS_ILLEGAL) ? ST_DONE : ST_EXEC;
            ST_EXEC: begin
                case (w_class)
                    CLS_LOAD,
                    CLS_STORE: w_next_state = ST_MEM;
                    CLS_RTYPE: w_next_state = ST_WB;
                    default:   w_next_state = ST_DONE;
                endcase
            end
            ST_MEM:    w_next_state = (w_class == CLS_LOAD) ? ST_WB : ST_DONE;
            ST_WB:     w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Capture the instruction and branch offset only when a request is accepted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr     <= '0;
            r_br_offset <= '0;
        end else if (w_accept) begin
            r_instr     <= bus.instr;
            r_br_offset <= bus.instr[23:5];
        end
    end

    // Status flags and write strobes, derived from the state being entered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_illegal      <= 1'b0;
            r_branch_taken <= 1'b0;
            r_rf_clock     <= 1'b0;
            r_dm_clock     <= 1'b0;
        end else begin
            r_busy         <= (w_next_state != ST_IDLE);
            r_done         <= (w_next_state == ST_DONE);
            r_illegal      <= (w_next_state == ST_DONE) && (w_class == CLS_ILLEGAL);
            // Only CBZ leaves EXEC straight for DONE; Zero is sampled on that edge
            r_branch_taken <= (r_state == ST_EXEC) && (w_next_state == ST_DONE) && bus.Zero;
            r_rf_clock     <= (w_next_state == ST_WB);
            r_dm_clock     <= (w_next_state == ST_MEM) && (w_class == CLS_STORE);
        end
    end

    // Datapath controls and fields: loaded on entry to EXEC, controls cleared on return to IDLE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_op     <= ALUOP_NONE;
            r_opcode     <= '0;
            r_rn         <= '0;
            r_rm         <= '0;
            r_rt         <= '0;
            r_disp       <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg2loc    <= 1'b0;
        end else if (w_enter_exec) begin
            r_alu_op     <= w_alu_op;
            r_opcode     <= w_opcode;
            r_rn         <= w_rn;
            r_rm         <= w_rm;
            r_rt         <= w_rt;
            r_disp       <= w_disp;
            r_reg_write  <= w_reg_write;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_alu_src    <= w_alu_src;
            r_mem_to_reg <= w_mem_to_reg;
            r_reg2loc    <= w_reg2loc;
        end else if (w_next_state == ST_IDLE) begin
            r_alu_op     <= ALUOP_NONE;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_reg2loc    <= 1'b0;
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.illegal         = r_illegal;
    assign bus.branch_taken    = r_branch_taken;
    assign bus.br_offset       = r_br_offset;
    assign bus.ALUOp           = r_alu_op;
    assign bus.OpCodefield     = r_opcode;
    assign bus.Rn              = r_rn;
    assign bus.Rm              = r_rm;
    assign bus.Rt              = r_rt;
    assign bus.DispIn          = r_disp;
    assign bus.RegWrite        = r_reg_write;
    assign bus.MemRead         = r_mem_read;
    assign bus.MemWrite        = r_mem_write;
    assign bus.ALUSrc_Select   = r_alu_src;
    assign bus.MemtoReg_Select = r_mem_to_reg;
    assign bus.Reg2Loc_Select  = r_reg2loc;
    assign bus.RF_clock        = r_rf_clock;
    assign bus.DM_clock        = r_dm_clock;

endmodule

// File: tb/tb_rfaludm_sequencer.sv
// Self-checking bench for rfaludm_sequencer: directed LEGv8 vectors with
// literal expectations, then randomized traffic against a cycle-count model.
module tb_rfaludm_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rfaludm_sequencer_if bus();

    rfaludm_sequencer dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_ILL = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int cls_of(input logic [31:0] w);
        logic [10:0] op;
        op = w[31:21];
        if (w[31:24] == 8'b10110100) return C_CBZ;
        if (op == 11'b11111000010) return C_LD;
        if (op == 11'b11111000000) return C_ST;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        return C_ILL;
    endfunction

    // Cycles from the start cycle (cycle 0) to the done pulse
    function automatic int lat_of(input int c);
        case (c)
            C_R:   return 4;
            C_LD:  return 5;
            C_ST:  return 4;
            C_CBZ: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input int c);
        logic [31:0] w;
        w = $urandom;
        case (c)
            C_R: begin
                case ($urandom_range(0, 3))
                    0: w[31:21] = 11'b10001011000;
                    1: w[31:21] = 11'b11001011000;
                    2: w[31:21] = 11'b10001010000;
                    default: w[31:21] = 11'b10101010000;
                endcase
            end
            C_LD:  w[31:21] = 11'b11111000010;
            C_ST:  w[31:21] = 11'b11111000000;
            C_CBZ: w[31:24] = 8'b10110100;
            default: while (cls_of(w) != C_ILL) w = $urandom;
        endcase
        return w;
    endfunction

    // Reference model: k is the cycle number of the current transaction
    // (1 = first cycle after the accepting edge), k == latency is the done cycle.
    bit          m_active;
    int          m_k;
    int          m_cls;
    int          m_lat;
    logic [31:0] m_instr;
    logic [18:0] m_br;
    logic        m_zs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_cls    <= C_ILL;
            m_lat    <= 2;
            m_instr  <= '0;
            m_br     <= '0;
            m_zs     <= 1'b0;
        end else if (m_active) begin
            if (m_k == 2) m_zs <= bus.Zero;
            if (m_k == m_lat) begin
                m_active <= 1'b0;
                m_k      <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end else if (bus.start) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_instr  <= bus.instr;
            m_br     <= bus.instr[23:5];
            m_cls    <= cls_of(bus.instr);
            m_lat    <= lat_of(cls_of(bus.instr));
            m_zs     <= 1'b0;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin : compare
        logic       win, e_done;
        logic [1:0] e_op;
        logic       e_rw, e_mr, e_mw, e_src, e_m2r, e_r2l;
        win    = m_active && (m_cls != C_ILL) && (m_k >= 2);
        e_done = m_active && (m_k == m_lat);
        e_op = 2'b00; e_rw = 0; e_mr = 0; e_mw = 0; e_src = 0; e_m2r = 0; e_r2l = 0;
        if (win) begin
            case (m_cls)
                C_R:  begin e_op = 2'b10; e_rw = 1; e_m2r = 1; end
                C_LD: begin e_op = 2'b11; e_src = 1; e_mr = 1; e_rw = 1; end
                C_ST: begin e_op = 2'b11; e_src = 1; e_r2l = 1; e_mw = 1; end
                default: begin e_op = 2'b01; e_r2l = 1; end
            endcase
        end
        chk("busy", bus.busy, m_active);
        chk("done", bus.done, e_done);
        chk("RF_clock", bus.RF_clock,
            m_active && (m_cls == C_R || m_cls == C_LD) && (m_k == m_lat - 1));
        chk("DM_clock", bus.DM_clock, m_active && (m_cls == C_ST) && (m_k == 3));
        chk("ALUOp", bus.ALUOp, e_op);
        chk("RegWrite", bus.RegWrite, e_rw);
        chk("MemRead", bus.MemRead, e_mr);
        chk("MemWrite", bus.MemWrite, e_mw);
        chk("ALUSrc", bus.ALUSrc_Select, e_src);
        chk("MemtoReg", bus.MemtoReg_Select, e_m2r);
        chk("Reg2Loc", bus.Reg2Loc_Select, e_r2l);
        chk("br_offset", bus.br_offset, m_br);
        if (win) begin
            chk("OpCodefield", bus.OpCodefield, m_instr[31:21]);
            chk("Rn", bus.Rn, m_instr[9:5]);
            chk("Rm", bus.Rm, m_instr[20:16]);
            chk("Rt", bus.Rt, m_instr[4:0]);
            chk("DispIn", bus.DispIn, m_instr[20:12]);
        end
        if (e_done) begin
            chk("illegal", bus.illegal, m_cls == C_ILL);
            chk("branch_taken", bus.branch_taken, (m_cls == C_CBZ) && m_zs);
        end
    end

    // Issue one instruction and follow it to done; returns at the done cycle.
    // With noise set, start is toggled randomly while the sequencer is busy.
    task automatic issue(input logic [31:0] ins, input logic z, input bit noise,
                         output int lat, output int rf_mask, output int dm_mask);
        @(negedge clk); #1;
        bus.start = 1'b1;
        bus.instr = ins;
        bus.Zero  = z;
        lat = 0; rf_mask = 0; dm_mask = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.RF_clock) rf_mask |= (1 << c);
            if (bus.DM_clock) dm_mask |= (1 << c);
            if (bus.done) begin
                lat = c;
                break;
            end
            #1;
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) bus.instr = $urandom;
        end
        #1 bus.start = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat, rfm, dmm, cls;
        bit found;
        logic [31:0] ins;

        bus.start = 1'b0;
        bus.instr = '0;
        bus.Zero  = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset RF_clock", bus.RF_clock, 0);
        chk("reset br_offset", bus.br_offset, 0);
        chk("reset Rn", bus.Rn, 0);
        chk("reset OpCodefield", bus.OpCodefield, 0);
        #1 rst_n = 1'b1;

        // ADD X3,X1,X2
        issue(32'h8B020023, 1'b0, 1'b0, lat, rfm, dmm);
        chk("ADD latency", lat, 4);
        chk("ADD Rn", bus.Rn, 1);
        chk("ADD Rm", bus.Rm, 2);
        chk("ADD Rt", bus.Rt, 3);
        chk("ADD ALUOp", bus.ALUOp, 2'b10);
        chk("ADD MemtoReg", bus.MemtoReg_Select, 1);
        chk("ADD RF_clock cycles", rfm, 1 << 3);
        chk("ADD DM_clock cycles", dmm, 0);

        // start in the done cycle is ignored, the next cycle's start is accepted
        bus.start = 1'b1;
        bus.instr = 32'h8B020023;
        @(negedge clk);
        chk("start in done cycle ignored", bus.busy, 0);
        #1 bus.start = 1'b0;

        // LDUR X1,[X0,#40]
        issue(32'hF8428001, 1'b0, 1'b0, lat, rfm, dmm);
        chk("LDUR latency", lat, 5);
        chk("LDUR DispIn", bus.DispIn, 40);
        chk("LDUR ALUSrc", bus.ALUSrc_Select, 1);
        chk("LDUR MemRead", bus.MemRead, 1);
        chk("LDUR RF_clock cycles", rfm, 1 << 4);
        chk("LDUR DM_clock cycles", dmm, 0);

        // STUR X3,[X0,#0]
        issue(32'hF8000003, 1'b0, 1'b0, lat, rfm, dmm);
        chk("STUR latency", lat, 4);
        chk("STUR Reg2Loc", bus.Reg2Loc_Select, 1);
        chk("STUR MemWrite", bus.MemWrite, 1);
        chk("STUR DM_clock cycles", dmm, 1 << 3);
        chk("STUR RF_clock cycles", rfm, 0);

        // CBZ X4,#5 with Zero=1 then Zero=0
        issue(32'hB40000A4, 1'b1, 1'b0, lat, rfm, dmm);
        chk("CBZ latency", lat, 3);
        chk("CBZ taken", bus.branch_taken, 1);
        chk("CBZ br_offset", bus.br_offset, 5);
        issue(32'hB40000A4, 1'b0, 1'b0, lat, rfm, dmm);
        chk("CBZ not taken", bus.branch_taken, 0);

        // Illegal opcode
        issue(32'h00000000, 1'b0, 1'b0, lat, rfm, dmm);
        chk("illegal latency", lat, 2);
        chk("illegal flag", bus.illegal, 1);
        chk("illegal strobes", rfm | dmm, 0);
        chk("illegal ALUOp", bus.ALUOp, 0);
        chk("illegal RegWrite", bus.RegWrite, 0);

        // Reset asserted in the WB cycle of an ADD
        @(negedge clk); #1;
        bus.start = 1'b1;
        bus.instr = 32'h8B020023;
        @(negedge clk); #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.RF_clock) found = 1'b1;
        end
        chk("ADD reached WB", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset clears RF_clock", bus.RF_clock, 0);
        chk("reset clears busy", bus.busy, 0);
        chk("reset clears RegWrite", bus.RegWrite, 0);
        chk("reset clears ALUOp", bus.ALUOp, 0);
        chk("reset clears Rn", bus.Rn, 0);
        @(negedge clk); #1 rst_n = 1'b1;

        // SUB X4,X1,X2 after reset, with start noise while busy
        issue(32'hCB020024, 1'b0, 1'b1, lat, rfm, dmm);
        chk("SUB latency", lat, 4);
        chk("SUB Rt", bus.Rt, 4);
        chk("SUB OpCodefield", bus.OpCodefield, 11'b11001011000);
        chk("SUB RF_clock cycles", rfm, 1 << 3);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            cls = $urandom_range(0, 4);
            ins = rand_instr(cls);
            issue(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lat, rfm, dmm);
            chk("random latency", lat, lat_of(cls));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rfaludm_sequencer.md
# rfaludm_sequencer

Multicycle control sequencer that drives the RFALUDM datapath (register file + ALU + data memory) from one 32-bit LEGv8 instruction at a time. It accepts an instruction on a start pulse, decodes it, and steps the datapath through EXEC, MEM and WB phases. It generates every datapath control and the RF/DM write strobes, then reports done, branch outcome and illegal-opcode status. It replaces hand-driven control sequences in bring-up benches and is the seed of the CPU control unit.

## Interface
- No parameters.
- clock  in  1  single system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; samples instr when idle.
- instr  in  32  LEGv8 instruction word.
- Zero  in  1  ALU zero flag from RFALUDM.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse in DONE.
- illegal  out  1  valid with done; opcode not supported.
- branch_taken  out  1  valid with done; CBZ and Zero=1.
- br_offset  out  19  CBZ cond_br_addr, instr[23:5], held until next start.
- ALUOp  out  2, OpCodefield  out  11, Rn/Rm/Rt  out  5 each, DispIn  out  9: datapath fields.
- RegWrite, MemRead, MemWrite, ALUSrc_Select, MemtoReg_Select, Reg2Loc_Select  out  1 each: datapath controls.
- RF_clock, DM_clock  out  1 each: register-file and data-memory write strobes.

## Operation
- Supported opcodes (instr[31:21]): LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000; CBZ instr[31:24]=10110100. All other opcodes are illegal.
- Fields: Rt=instr[4:0], Rn=instr[9:5], Rm=instr[20:16], DispIn=instr[20:12], OpCodefield=instr[31:21].
- ALUOp encodings: 2'b11 D-format address add, 2'b10 R-type (ALU decodes OpCodefield), 2'b01 CBZ pass-B.
- MemtoReg_Select: 1 selects the ALU result, 0 selects memory data. Reg2Loc_Select: 1 reads Rt on port 2. ALUSrc_Select: 1 selects DispIn.
- R-type: ALUOp=10, ALUSrc=0, Reg2Loc=0, MemtoReg=1, RegWrite=1.
- LDUR: ALUOp=11, ALUSrc=1, MemRead=1, MemtoReg=0, RegWrite=1.
- STUR: ALUOp=11, ALUSrc=1, Reg2Loc=1, MemWrite=1, RegWrite=0.
- CBZ: ALUOp=01, ALUSrc=0, Reg2Loc=1, no writes. branch_taken=Zero, sampled on the last EXEC edge.
- FSM states: IDLE, DECODE, EXEC, MEM, WB, DONE.
- Transitions:
  - IDLE → DECODE on start.
  - DECODE → EXEC; an illegal opcode goes directly to DONE.
  - EXEC → MEM for LDUR/STUR, → WB for R-type, → DONE for CBZ.
  - MEM → WB for LDUR, → DONE for STUR.
  - WB → DONE.
  - DONE → IDLE.
- start while busy is ignored. instr is captured only on the IDLE→DECODE edge.

## Timing
- All outputs are registered. Reset value of every output is 0, including strobes, fields and br_offset. State resets to IDLE.
- Call the start edge cycle 0. Latency to the done pulse:
  - R-type: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ: 3 cycles.
  - Illegal: 2 cycles.
- Datapath fields and controls become valid in EXEC and are held stable through DONE. All controls return to 0 on entry to IDLE.
- RF_clock is high for exactly the WB cycle. RegWrite is already high from EXEC, which gives a full cycle of setup.
- DM_clock is high for exactly the MEM cycle, and only for STUR. MemWrite and MemRead are asserted from EXEC.
- An illegal opcode produces no strobes and leaves all controls at 0. illegal=1 with done.
- Asynchronous reset mid-operation clears all strobes immediately, so no partial write completes. The next start begins normally.
- start asserted in the same cycle as done is ignored. start asserted on the following cycle (in IDLE) is accepted.

## Structure
- Shared package rfaludm_pkg holds:
  - the opcode constants;
  - the ALUOp encodings;
  - the FSM state encoding.
- Sub-module rfaludm_decode: combinational decode of instr into an instruction class (RTYPE, LOAD, STORE, CBZ, ILLEGAL) plus fields. The sequencer holds the FSM and output registers.

## Test plan
- ADD X3,X1,X2 (0x8B020023) → done at cycle 4. Controls: Rn=1, Rm=2, Rt=3, ALUOp=10, MemtoReg=1. RF_clock high only in cycle 3.
- LDUR X1,[X0,#40] (0xF8428001) → DispIn=40, ALUSrc=1, MemRead=1. DM_clock stays 0. RF_clock high in cycle 4. done at cycle 5.
- STUR X3,[X0,#0] (0xF8000003) → Reg2Loc=1, MemWrite=1. DM_clock high only in cycle 3. RF_clock never high. done at cycle 4.
- CBZ X4,#5 (0xB40000A4) → with Zero=1, done at cycle 3 with branch_taken=1 and br_offset=5. Repeat with Zero=0: branch_taken=0.
- instr 0x00000000 → done at cycle 2 with illegal=1. No strobes, all controls 0.
- reset_n low during the WB cycle of an ADD → RF_clock and all outputs drop to 0 immediately. After release, a new SUB (0xCB020024) completes normally. start pulses issued while busy produce no extra done.
